alu_op_decoder: RTL

- Registered RV32I decode stage that produces the 4-bit ALU opcode and operand controls consumed by the core's ALU.
- The ALU opcode is {funct7[5], funct3}: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- Sits between instruction fetch and the execute stage, with valid/ready on both sides.
- Contains a 2-entry skid buffer so that in_ready is a registered signal.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_op_decoder_imm_gen.sv | 30 +++
 rtl/alu_op_decoder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the RV32I ALU decode stage: ALU opcodes, major opcodes,
// immediate formats and the decoded bundle held in each buffer entry.
package alu_pkg;

  localparam int IMM_W = 32;

  // ALU opcode is {funct7[5], funct3}
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_SHAMT
  } imm_type_e;

  typedef struct packed {
    alu_op_e          alu_op;
    logic             use_imm;
    logic [IMM_W-1:0] imm;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             reg_we;
    logic             illegal;
  } dec_bundle_t;

endpackage

// File: rtl/alu_op_decoder_imm_gen.sv
// Combinational RV32I immediate generator: extracts and extends the
// immediate of the selected format from a raw instruction word.
module imm_gen
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  // Opcode bits never carry immediate data.
  logic unused_opc;
  assign unused_opc = ^instr[6:0];

  // Assemble the immediate for the requested format
  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:     imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:     imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:     imm = {instr[31:12], 12'b0};
      IMM_SHAMT: imm = {27'b0, instr[24:20]};
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_decoder.sv
// Registered RV32I ALU decode stage with a main output register and one skid
// entry so that in_ready comes straight from a flop.
// Optional build macro DEC_PERF_CNT_EN adds saturating perf_decoded and
// perf_illegal handshake counters.
module alu_op_decoder
  import alu_pkg::*;
#(
  parameter int         XLEN           = 32,
  parameter logic [3:0] ILLEGAL_ALU_OP = 4'b0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic            out_use_imm,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_reg_we,
  output logic            out_illegal
`ifdef DEC_PERF_CNT_EN
  ,
  output logic [31:0]     perf_decoded,
  output logic [31:0]     perf_illegal
`endif
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  imm_type_e   imm_sel;
  logic        imm_en;
  logic [XLEN-1:0] imm_val;
  dec_bundle_t dec_raw;
  dec_bundle_t dec_p0;

  dec_bundle_t main_p1;
  dec_bundle_t skid_p1;
  logic        vld_p1;
  logic        skid_vld_p1;
  logic        accept;
  logic        load_main;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr    (in_instr),
    .imm_type (imm_sel),
    .imm      (imm_val)
  );

  // Decode opcode/funct fields into ALU controls and pick the immediate format
  always_comb begin
    dec_raw         = '0;
    dec_raw.alu_op  = ALU_ADD;
    dec_raw.rs1     = in_instr[19:15];
    dec_raw.rs2     = in_instr[24:20];
    dec_raw.rd      = in_instr[11:7];
    imm_sel         = IMM_I;
    imm_en          = 1'b0;
    case (opc)
      OPC_OP: begin
        dec_raw.alu_op = alu_op_e'({f7[5], f3});
        dec_raw.reg_we = 1'b1;
        if (!((f7 == 7'b0000000) ||
              (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
          dec_raw.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_raw.use_imm = 1'b1;
        dec_raw.reg_we  = 1'b1;
        imm_en          = 1'b1;
        if (f3 == 3'b001) begin
          imm_sel        = IMM_SHAMT;
          dec_raw.alu_op = ALU_SLL;
          if (f7 != 7'b0000000) dec_raw.illegal = 1'b1;
        end else if (f3 == 3'b101) begin
          imm_sel = IMM_SHAMT;
          if (f7 == 7'b0000000)      dec_raw.alu_op = ALU_SRL;
          else if (f7 == 7'b0100000) dec_raw.alu_op = ALU_SRA;
          else                       dec_raw.illegal = 1'b1;
        end else begin
          dec_raw.alu_op = alu_op_e'({1'b0, f3});
        end
      end
      OPC_LOAD: begin
        dec_raw.use_imm = 1'b1;
        dec_raw.reg_we  = 1'b1;
        imm_en          = 1'b1;
      end
      OPC_STORE: begin
        dec_raw.use_imm = 1'b1;
        imm_sel         = IMM_S;
        imm_en          = 1'b1;
      end
      OPC_BRANCH: begin
        imm_sel = IMM_B;
        imm_en  = 1'b1;
        case (f3)
          3'b000, 3'b001: dec_raw.alu_op = ALU_SUB;
          3'b100, 3'b101: dec_raw.alu_op = ALU_SLT;
          3'b110, 3'b111: dec_raw.alu_op = ALU_SLTU;
          default:        dec_raw.illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec_raw.rs1     = 5'd0;
        dec_raw.use_imm = 1'b1;
        dec_raw.reg_we  = 1'b1;
        imm_sel         = IMM_U;
        imm_en          = 1'b1;
      end
      default: dec_raw.illegal = 1'b1;
    endcase
    if (dec_raw.illegal) begin
      dec_raw.alu_op  = alu_op_e'(ILLEGAL_ALU_OP);
      dec_raw.reg_we  = 1'b0;
      dec_raw.use_imm = 1'b0;
      imm_en          = 1'b0;
    end
  end

  // Merge the generated immediate into the decoded bundle
  always_comb begin
    dec_p0     = dec_raw;
    dec_p0.imm = imm_en ? imm_val : '0;
  end

  // ---- stage boundary: decode -> main/skid output registers ----
  assign in_ready  = !skid_vld_p1;
  assign accept    = in_valid && in_ready;
  assign load_main = !vld_p1 || out_ready;

  // Main register reloads from skid first (keeps order), else from decode;
  // input arriving while main is stalled parks in the skid entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_p1     <= '0;
      skid_p1     <= '0;
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (load_main) begin
      if (skid_vld_p1) begin
        main_p1     <= skid_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else if (accept) begin
        main_p1 <= dec_p0;
        vld_p1  <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (accept) begin
      skid_p1     <= dec_p0;
      skid_vld_p1 <= 1'b1;
    end
  end

  assign out_valid   = vld_p1;
  assign out_alu_op  = main_p1.alu_op;
  assign out_use_imm = main_p1.use_imm;
  assign out_imm     = main_p1.imm;
  assign out_rs1     = main_p1.rs1;
  assign out_rs2     = main_p1.rs2;
  assign out_rd      = main_p1.rd;
  assign out_reg_we  = main_p1.reg_we;
  assign out_illegal = main_p1.illegal;

`ifdef DEC_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic out_fire;
  assign out_fire = vld_p1 && out_ready;

  // Count output handshakes, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_decoded <= '0;
      perf_illegal <= '0;
    end else if (out_fire) begin
      perf_decoded <= sat_inc(perf_decoded);
      if (main_p1.illegal) perf_illegal <= sat_inc(perf_illegal);
    end
  end
`endif

endmodule
